// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from
// execute, and the instruction handshake towards decode.
interface fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word fetch, in-order response buffer
// feeding decode, and redirect flush that discards stale in-flight responses.
module fetch_unit #(
    parameter int unsigned         PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t state, state_n;

    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic [PC_WIDTH-1:0] resp_pc, resp_pc_n;
    logic [PC_WIDTH-1:0] target;
    logic [CW-1:0]       inflight, inflight_n;
    logic [CW-1:0]       drop, drop_n;
    logic [CW-1:0]       count, count_n;
    logic [AW-1:0]       wr_ptr, wr_ptr_n;
    logic [AW-1:0]       rd_ptr, rd_ptr_n;
    logic [SW-1:0]       outstanding;
    logic                head_valid;
    logic                req_fire;
    logic                resp_toss;
    logic                push;
    logic                pop;

    logic [PC_WIDTH-1:0] pc_buf    [DEPTH];
    logic [31:0]         instr_buf [DEPTH];

    // Credit covers new-path flights, old-path flights awaiting discard and buffered words.
    assign outstanding        = SW'(inflight) + SW'(drop) + SW'(count);
    assign bus.imem_req_valid = (state == ST_RUN) && (outstanding < SW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign head_valid      = (count != '0);
    assign bus.instr_valid = head_valid;
    assign bus.instruction = head_valid ? instr_buf[rd_ptr] : '0;
    assign bus.instr_pc    = head_valid ? pc_buf[rd_ptr] : '0;

    assign target    = bus.redirect_pc & ~PC_WIDTH'(3);
    assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
    assign resp_toss = bus.imem_resp_valid & (drop != '0);
    assign push      = bus.imem_resp_valid & (drop == '0) & ~bus.redirect;
    assign pop       = head_valid & bus.instr_ready;

    always_comb begin
        state_n = state;
        case (state)
            ST_HOLD: state_n = ST_RUN;
            ST_RUN:  state_n = ST_RUN;
            default: state_n = ST_HOLD;
        endcase
    end

    always_comb begin
        fetch_pc_n = fetch_pc;
        resp_pc_n  = resp_pc;
        inflight_n = inflight;
        drop_n     = drop;
        count_n    = count;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        if (bus.redirect) begin
            // Every old-path flight moves to drop; a response arriving now is
            // discarded whether it would have hit drop or inflight.
            drop_n     = drop + inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
            inflight_n = '0;
            count_n    = '0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            fetch_pc_n = target;
            resp_pc_n  = target;
        end else begin
            if (req_fire) begin
                fetch_pc_n = fetch_pc + PC_WIDTH'(4);
            end
            if (resp_toss) begin
                drop_n = drop - CW'(1);
            end
            if (push) begin
                resp_pc_n = resp_pc + PC_WIDTH'(4);
                wr_ptr_n  = wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + AW'(1);
            end
            inflight_n = inflight + CW'(req_fire) - CW'(push);
            count_n    = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            resp_pc  <= resp_pc_n;
            inflight <= inflight_n;
            drop     <= drop_n;
            count    <= count_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]    <= resp_pc;
            instr_buf[wr_ptr] <= bus.imem_resp_data;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable memory model and an
// expected-instruction queue checked at every decode handshake.
module tb_fetch_unit;
    localparam int unsigned PCW   = 16;
    localparam int unsigned DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if #(.PC_WIDTH(PCW)) bus ();

    fetch_unit #(
        .PC_WIDTH (PCW),
        .RESET_PC (16'h0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ins;
    } entry_t;

    typedef struct packed {
        logic [31:0] due;
        logic [15:0] addr;
    } mreq_t;

    entry_t      exp_q[$];
    mreq_t       pend[$];
    int unsigned cyc        = 0;
    int unsigned lat        = 1;
    int unsigned nreq       = 0;
    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h003100B3;
            16'h0004: return 32'h00510093;
            16'h0008: return 32'h00312423;
            default:  return {16'h1300, a};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_run(input logic [15:0] start, input int unsigned n);
        logic [15:0] a;
        a = start;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back('{pc: a, ins: mem_word(a)});
            a = a + 16'd4;
        end
    endtask

    // Returns at posedge+2 with instr_ready low once every expected word was consumed.
    task automatic drain(input int unsigned max_cycles);
        for (int unsigned i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #2 bus.instr_ready = 1'b0;
        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_redirect(input logic [15:0] tgt);
        bus.redirect_pc = tgt;
        bus.redirect    = 1'b1;
        @(posedge clk);
        #2 bus.redirect = 1'b0;
    endtask

    // Memory: accept on negedge sample, answer in-order after lat cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{due: cyc + lat, addr: bus.imem_req_addr});
            nreq++;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    end

    always @(negedge clk) begin
        entry_t got, want;
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            got = '{pc: bus.instr_pc, ins: bus.instruction};
            if (exp_q.size() == 0) begin
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL unexpected_instr: got %h expected none", got);
                end
            end else begin
                want = exp_q.pop_front();
                chk("instr_stream", got, want);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid",   48'(bus.imem_req_valid), 48'h0);
        chk("rst_instr_valid", 48'(bus.instr_valid),    48'h0);
        chk("rst_instruction", 48'(bus.instruction),    48'h0);
        chk("rst_instr_pc",    48'(bus.instr_pc),       48'h0);
        chk("rst_req_addr",    48'(bus.imem_req_addr),  48'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid_c1", 48'(bus.imem_req_valid), 48'h0);
        @(negedge clk);
        chk("post_rst_valid_c2", 48'(bus.imem_req_valid), 48'h1);
        chk("first_req_addr",    48'(bus.imem_req_addr),  48'h0);

        // backpressure from the start
        repeat (8) @(negedge clk);
        chk("bp_nreq",       48'(nreq),               48'(DEPTH));
        chk("bp_req_valid",  48'(bus.imem_req_valid), 48'h0);
        chk("bp_head_valid", 48'(bus.instr_valid),    48'h1);
        chk("bp_head",       {bus.instr_pc, bus.instruction}, {16'h0000, 32'h003100B3});
        repeat (3) @(negedge clk);
        chk("bp_head_hold",  {bus.instr_pc, bus.instruction}, {16'h0000, 32'h003100B3});
        chk("bp_nreq_hold",  48'(nreq),               48'(DEPTH));

        // release: in-order stream, no loss or duplication
        push_run(16'h0000, 6);
        @(posedge clk);
        #2 bus.instr_ready = 1'b1;
        drain(80);
        repeat (8) @(posedge clk);

        // redirect with two old-path requests in flight, memory latency 3
        lat = 3;
        #2 pulse_redirect(16'h0040);
        for (int unsigned i = 0; i < 10; i++) begin
            if (pend.size() == 2) break;
            @(posedge clk);
            #2;
        end
        chk("d_two_inflight", 48'(pend.size()), 48'h2);
        pulse_redirect(16'h0102);
        @(negedge clk);
        chk("d_redir_addr",   48'(bus.imem_req_addr),  48'h0100);
        chk("d_drain_credit", 48'(bus.imem_req_valid), 48'h0);
        chk("d_valid_off",    48'(bus.instr_valid),    48'h0);
        push_run(16'h0100, 3);
        bus.instr_ready = 1'b1;
        drain(80);
        repeat (12) @(posedge clk);
        lat = 1;
        repeat (4) @(posedge clk);

        // redirect coinciding with a response and a pop
        #2 push_run(16'h0200, 1);
        pulse_redirect(16'h0200);
        bus.instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 bus.redirect_pc = 16'h0300;
        bus.redirect = 1'b1;
        @(negedge clk);
        chk("e_head",      {bus.instr_pc, bus.instruction}, {16'h0200, mem_word(16'h0200)});
        chk("e_resp_same", 48'(bus.imem_resp_valid), 48'h1);
        @(posedge clk);
        #2 bus.redirect = 1'b0;
        push_run(16'h0300, 3);
        @(negedge clk);
        chk("e_valid_off", 48'(bus.instr_valid), 48'h0);
        drain(80);
        repeat (8) @(posedge clk);

        // address wrap
        push_run(16'hFFF8, 3);
        #2 pulse_redirect(16'hFFF8);
        bus.instr_ready = 1'b1;
        drain(80);
        repeat (8) @(posedge clk);

        // asynchronous reset between edges
        @(negedge clk);
        chk("g_pre_valid", 48'(bus.instr_valid), 48'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("g_instr_valid", 48'(bus.instr_valid),    48'h0);
        chk("g_instruction", 48'(bus.instruction),    48'h0);
        chk("g_instr_pc",    48'(bus.instr_pc),       48'h0);
        chk("g_req_valid",   48'(bus.imem_req_valid), 48'h0);
        chk("g_req_addr",    48'(bus.imem_req_addr),  48'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        push_run(16'h0000, 2);
        @(negedge clk);
        chk("g_valid_c1", 48'(bus.imem_req_valid), 48'h0);
        @(negedge clk);
        chk("g_valid_c2", 48'(bus.imem_req_valid), 48'h1);
        chk("g_addr",     48'(bus.imem_req_addr),  48'h0);
        bus.instr_ready = 1'b1;
        drain(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
